// File: rtl/mem_pkg.sv
// ============================================================================
// mem_pkg : shared types and constants for the memory responder
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  localparam logic [7:0]  IO_ADDR_DEFAULT = 8'hFF;
  localparam int unsigned WAIT_CYCLES_MAX = 15;

endpackage

`default_nettype wire

// File: rtl/mem_array.sv
// ============================================================================
// mem_array : 2^ADDR_W x DATA_W storage, transaction/load write mux, async read
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_array #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clock,
  input  logic              txn_we_i,
  input  logic [ADDR_W-1:0] txn_addr_i,
  input  logic [DATA_W-1:0] txn_data_i,
  input  logic              load_we_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [0:DEPTH-1];

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  // Transaction port has priority; the controller never raises both anyway.
  assign we    = txn_we_i | load_we_i;
  assign waddr = txn_we_i ? txn_addr_i : load_addr_i;
  assign wdata = txn_we_i ? txn_data_i : load_data_i;

  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
// mem_responder : wait-stated memory slave with 4-phase handshake and one I/O reg
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned     DATA_W      = 8,
  parameter int unsigned     ADDR_W      = 8,
  parameter int unsigned     WAIT_CYCLES = 2,
  parameter logic [ADDR_W-1:0] IO_ADDR   = ADDR_W'(IO_ADDR_DEFAULT)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              MemReady,
  output logic              MemBusy,
  output logic              err,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic [DATA_W-1:0] io_in,
  output logic [DATA_W-1:0] io_out
);

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_e            state_q,  state_d;
  logic [3:0]        cnt_q,    cnt_d;
  op_e               op_q,     op_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic [DATA_W-1:0] wdata_q,  wdata_d;
  logic [DATA_W-1:0] rdata_q,  rdata_d;
  logic [DATA_W-1:0] io_out_q, io_out_d;
  logic              err_q,    err_d;

  logic              txn_we;
  logic              load_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              req_none;

  assign req_none = ~MemRead & ~MemWrite;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      op_q     <= OP_READ;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      io_out_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      io_out_q <= io_out_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    io_out_d = io_out_q;
    err_d    = err_q;
    txn_we   = 1'b0;
    load_we  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (MemRead != MemWrite) begin
          addr_d  = addr;
          wdata_d = wdata;
          op_d    = MemWrite ? OP_WRITE : OP_READ;
          cnt_d   = CNT_INIT;
          state_d = (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
        end else if (MemRead && MemWrite) begin
          // Illegal request: flag it and complete the handshake without access.
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (load_en) begin
          load_we = 1'b1;
        end
      end

      ST_WAIT: begin
        if (req_none) begin
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_ACCESS: begin
        if (op_q == OP_WRITE) begin
          if (addr_q == IO_ADDR) begin
            io_out_d = wdata_q;
          end else begin
            txn_we = 1'b1;
          end
        end else begin
          rdata_d = (addr_q == IO_ADDR) ? io_in : mem_rdata;
        end
        state_d = ST_DONE;
      end

      ST_DONE: begin
        if (req_none) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clock       (clock),
    .txn_we_i    (txn_we),
    .txn_addr_i  (addr_q),
    .txn_data_i  (wdata_q),
    .load_we_i   (load_we),
    .load_addr_i (load_addr),
    .load_data_i (load_data),
    .raddr_i     (addr_q),
    .rdata_o     (mem_rdata)
  );

  assign rdata    = rdata_q;
  assign io_out   = io_out_q;
  assign err      = err_q;
  assign MemReady = (state_q == ST_DONE);
  assign MemBusy  = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// tb_mem_responder : random and directed checks of mem_responder against a model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_responder;

  localparam int W_MAIN = 2;
  localparam logic [7:0] IO_A = 8'hFF;

  logic       clock, reset;
  logic       MemRead, MemWrite, load_en;
  logic [7:0] addr, wdata, load_addr, load_data, io_in;
  logic [7:0] rdata, io_out;
  logic       MemReady, MemBusy, err;

  logic       MemRead0, MemWrite0;
  logic [7:0] addr0, wdata0, rdata0, io_out0;
  logic       MemReady0, MemBusy0, err0;

  int total = 0;
  int bad   = 0;

  logic [7:0] model_mem [0:255];
  logic [7:0] model_rdata;
  logic [7:0] model_io;
  logic       model_err;

  mem_responder #(.DATA_W(8), .ADDR_W(8), .WAIT_CYCLES(W_MAIN), .IO_ADDR(IO_A)) dut (
    .clock(clock), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .addr(addr), .wdata(wdata), .rdata(rdata), .MemReady(MemReady),
    .MemBusy(MemBusy), .err(err), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .io_in(io_in), .io_out(io_out)
  );

  mem_responder #(.DATA_W(8), .ADDR_W(8), .WAIT_CYCLES(0), .IO_ADDR(IO_A)) dut0 (
    .clock(clock), .reset(reset), .MemRead(MemRead0), .MemWrite(MemWrite0),
    .addr(addr0), .wdata(wdata0), .rdata(rdata0), .MemReady(MemReady0),
    .MemBusy(MemBusy0), .err(err0), .load_en(1'b0), .load_addr(8'h00),
    .load_data(8'h00), .io_in(8'h00), .io_out(io_out0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full transaction on the main instance; called and returns at a falling edge.
  task automatic xact(input bit wr, input logic [7:0] a, input logic [7:0] d,
                      input bit scramble, input bit with_load);
    int n;
    bit got;
    logic [7:0] la;
    la = a ^ 8'h01;
    MemRead  = ~wr;
    MemWrite = wr;
    addr     = a;
    wdata    = d;
    if (with_load) begin
      load_en   = 1'b1;
      load_addr = la;
      load_data = ~model_mem[la];
    end
    n = 0;
    got = 1'b0;
    while (n < 30 && !got) begin
      @(negedge clock);
      n++;
      if (n == 1) chk("busy_after_sample", MemBusy, 1'b1);
      if (scramble) begin
        addr  = 8'($urandom);
        wdata = 8'($urandom);
      end
      if (MemReady) got = 1'b1;
    end
    chk("latency", n - 1, W_MAIN + 1);
    if (wr) begin
      if (a == IO_A) model_io = d;
      else           model_mem[a] = d;
    end else begin
      model_rdata = (a == IO_A) ? io_in : model_mem[a];
    end
    chk("rdata", rdata, model_rdata);
    chk("io_out", io_out, model_io);
    chk("err", err, model_err);
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    load_en  = 1'b0;
    @(negedge clock);
    chk("ready_drop", MemReady, 1'b0);
    chk("busy_drop", MemBusy, 1'b0);
  endtask

  task automatic xact0(input bit wr, input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] exp_rd);
    int n;
    bit got;
    MemRead0  = ~wr;
    MemWrite0 = wr;
    addr0     = a;
    wdata0    = d;
    n = 0;
    got = 1'b0;
    while (n < 30 && !got) begin
      @(negedge clock);
      n++;
      if (MemReady0) got = 1'b1;
    end
    chk("w0_latency", n - 1, 1);
    if (!wr) chk("w0_rdata", rdata0, exp_rd);
    MemRead0  = 1'b0;
    MemWrite0 = 1'b0;
    @(negedge clock);
    chk("w0_busy_drop", MemBusy0, 1'b0);
  endtask

  initial begin
    logic [7:0] a, d;
    bit wr, ready_seen;

    reset = 1'b1;
    {MemRead, MemWrite, load_en, MemRead0, MemWrite0} = '0;
    addr = 0; wdata = 0; load_addr = 0; load_data = 0; io_in = 0;
    addr0 = 0; wdata0 = 0;
    model_rdata = 0; model_io = 0; model_err = 0;

    repeat (2) @(negedge clock);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_ready", MemReady, 1'b0);
    chk("rst_busy", MemBusy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_io_out", io_out, 8'h00);
    reset = 1'b0;
    @(negedge clock);

    // Backdoor-fill the whole array so every location has a known value.
    for (int i = 0; i < 256; i++) begin
      load_en   = 1'b1;
      load_addr = 8'(i);
      load_data = 8'($urandom);
      model_mem[i] = load_data;
      @(negedge clock);
    end
    load_en = 1'b0;

    // Directed load then read.
    load_en = 1'b1; load_addr = 8'h10; load_data = 8'h3C;
    model_mem[8'h10] = 8'h3C;
    @(negedge clock);
    load_en = 1'b0;
    xact(1'b0, 8'h10, 8'h00, 1'b0, 1'b0);
    chk("load_read_3c", rdata, 8'h3C);

    // Zero-wait instance: write then readback.
    xact0(1'b1, 8'h20, 8'hA5, 8'h00);
    xact0(1'b0, 8'h20, 8'h00, 8'hA5);

    // I/O register write and read.
    xact(1'b1, IO_A, 8'h5A, 1'b0, 1'b0);
    chk("io_out_5a", io_out, 8'h5A);
    chk("io_mem_keep", dut.u_array.mem_q[8'hFF], model_mem[8'hFF]);
    io_in = 8'h77;
    xact(1'b0, IO_A, 8'h00, 1'b0, 1'b0);
    chk("io_read_77", rdata, 8'h77);

    // Randomized traffic, with inputs scrambled after sampling on some.
    for (int k = 0; k < 40; k++) begin
      wr    = 1'($urandom);
      a     = ($urandom_range(0, 7) == 0) ? IO_A : 8'($urandom);
      d     = 8'($urandom);
      io_in = 8'($urandom);
      xact(wr, a, d, 1'($urandom), 1'b0);
    end

    // Load strobe held during a request must be ignored.
    xact(1'b1, 8'h40, 8'h99, 1'b0, 1'b1);
    xact(1'b0, 8'h41, 8'h00, 1'b0, 1'b0);
    chk("load_ignored", rdata, model_mem[8'h41]);

    // Abort while in WAIT.
    MemWrite = 1'b1; addr = 8'h30; wdata = 8'h11;
    @(negedge clock);
    chk("abort_busy", MemBusy, 1'b1);
    MemWrite = 1'b0;
    ready_seen = 1'b0;
    repeat (5) begin
      @(negedge clock);
      if (MemReady) ready_seen = 1'b1;
    end
    chk("abort_no_ready", ready_seen, 1'b0);
    chk("abort_idle", MemBusy, 1'b0);
    xact(1'b0, 8'h30, 8'h00, 1'b0, 1'b0);
    chk("abort_mem_keep", rdata, model_mem[8'h30]);

    // Both requests high: error path.
    MemRead = 1'b1; MemWrite = 1'b1; addr = 8'h31; wdata = 8'hEE;
    @(negedge clock);
    model_err = 1'b1;
    chk("err_ready", MemReady, 1'b1);
    chk("err_set", err, 1'b1);
    chk("err_rdata_keep", rdata, model_rdata);
    repeat (3) @(negedge clock);
    chk("err_ready_hold", MemReady, 1'b1);
    MemRead = 1'b0; MemWrite = 1'b0;
    @(negedge clock);
    chk("err_ready_drop", MemReady, 1'b0);
    chk("err_sticky", err, 1'b1);
    xact(1'b0, 8'h31, 8'h00, 1'b0, 1'b0);
    chk("err_mem_keep", rdata, model_mem[8'h31]);

    // Reset during WAIT of a write.
    MemWrite = 1'b1; addr = 8'h50; wdata = ~model_mem[8'h50];
    @(negedge clock);
    reset = 1'b1;
    #1;
    model_rdata = 0; model_io = 0; model_err = 0;
    chk("mid_rst_rdata", rdata, 8'h00);
    chk("mid_rst_ready", MemReady, 1'b0);
    chk("mid_rst_busy", MemBusy, 1'b0);
    chk("mid_rst_err", err, 1'b0);
    chk("mid_rst_io_out", io_out, 8'h00);
    MemWrite = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    xact(1'b0, 8'h50, 8'h00, 1'b0, 1'b0);
    chk("rst_target_keep", rdata, model_mem[8'h50]);
    xact(1'b0, 8'h10, 8'h00, 1'b0, 1'b0);
    chk("rst_preload_keep", rdata, model_mem[8'h10]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
